// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus types: one-hot arbiter states and request-type codes.
// Imported by cpu_mem_arbiter.
package cpu_bus_pkg;

  localparam int S_IDLE  = 0;
  localparam int S_IREQ  = 1;
  localparam int S_IRSP  = 2;
  localparam int S_DRREQ = 3;
  localparam int S_DRRSP = 4;
  localparam int S_DWREQ = 5;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    I_REQ     = 6'b000010,
    I_RESP    = 6'b000100,
    D_RD_REQ  = 6'b001000,
    D_RD_RESP = 6'b010000,
    D_WR_REQ  = 6'b100000
  } state_e;

  typedef enum logic [1:0] {
    RT_INST = 2'd0,
    RT_DRD  = 2'd1,
    RT_DWR  = 2'd2
  } req_type_e;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU fetch/data channels onto one memory port (data first).
// Ports: clk/rst, CPU inst + data req/resp, mem req/resp, conflict_cnt.
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ready,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ready,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic                Mem_Req_Ready,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wen,
  output logic                mem_ren,
  input  logic                mem_req_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdata_valid,
  output logic                mem_rdata_ready,
  output logic [31:0]         conflict_cnt
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q;
  req_type_e           rtype_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                ren_q;
  logic                wen_q;
  logic [31:0]         cnt_q;

  logic d_req;
  logic idle;
  logic i_rsp;
  logic d_rsp;

  assign d_req = MemWrite | MemRead;
  // rst gate keeps the accept strobes low while reset is held
  assign idle  = state_q[S_IDLE] & ~rst;
  assign i_rsp = state_q[S_IRSP];
  assign d_rsp = state_q[S_DRRSP];

  assign Mem_Req_Ready  = idle & d_req;
  assign Inst_Req_Ready = idle & Inst_Req_Valid & ~d_req;

  assign Instruction     = i_rsp ? mem_rdata : '0;
  assign Inst_Valid      = i_rsp & mem_rdata_valid;
  assign Read_data       = d_rsp ? mem_rdata : '0;
  assign Read_data_Valid = d_rsp & mem_rdata_valid;
  assign mem_rdata_ready = (i_rsp & Inst_Ready) |
                           (d_rsp & Read_data_Ready);

  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_ren      = ren_q;
  assign mem_wen      = wen_q;
  assign conflict_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rtype_q <= RT_INST;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (1'b1)
        state_q[S_IDLE]: begin
          if (d_req & Inst_Req_Valid)
            cnt_q <= cnt_q + 32'd1;
          if (MemWrite) begin
            state_q <= D_WR_REQ;
            rtype_q <= RT_DWR;
            addr_q  <= Address;
            wdata_q <= Write_data;
            wstrb_q <= Write_strb;
            wen_q   <= 1'b1;
          end else if (MemRead) begin
            state_q <= D_RD_REQ;
            rtype_q <= RT_DRD;
            addr_q  <= Address;
            wdata_q <= '0;
            wstrb_q <= '0;
            ren_q   <= 1'b1;
          end else if (Inst_Req_Valid) begin
            state_q <= I_REQ;
            rtype_q <= RT_INST;
            addr_q  <= PC;
            wdata_q <= '0;
            wstrb_q <= '0;
            ren_q   <= 1'b1;
          end
        end
        state_q[S_IREQ], state_q[S_DRREQ]: begin
          if (mem_req_ready) begin
            ren_q <= 1'b0;
            if (rtype_q == RT_INST)
              state_q <= I_RESP;
            else
              state_q <= D_RD_RESP;
          end
        end
        state_q[S_DWREQ]: begin
          // writes complete on the request handshake
          if (mem_req_ready) begin
            wen_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        state_q[S_IRSP]: begin
          if (mem_rdata_valid & Inst_Ready)
            state_q <= IDLE;
        end
        state_q[S_DRRSP]: begin
          if (mem_rdata_valid & Read_data_Ready)
            state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: cycle vector table plus reset corner case.
// Memory-side requests are checked against a scoreboard queue.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemWrite;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_wen;
  logic        mem_ren;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_rdata_ready;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  cpu_mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .PC              (PC),
    .Inst_Req_Valid  (Inst_Req_Valid),
    .Inst_Req_Ready  (Inst_Req_Ready),
    .Instruction     (Instruction),
    .Inst_Valid      (Inst_Valid),
    .Inst_Ready      (Inst_Ready),
    .Address         (Address),
    .Write_data      (Write_data),
    .Write_strb      (Write_strb),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .Mem_Req_Ready   (Mem_Req_Ready),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_wen         (mem_wen),
    .mem_ren         (mem_ren),
    .mem_req_ready   (mem_req_ready),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata_ready (mem_rdata_ready),
    .conflict_cnt    (conflict_cnt)
  );

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic        irv;
    logic        iready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mw;
    logic        mr;
    logic        rdready;
    logic        mrr;
    logic [31:0] mrdata;
    logic        mrvalid;
    logic        e_irdy;
    logic        e_mrdy;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_ival;
    logic [31:0] e_instr;
    logic        e_rval;
    logic [31:0] e_rdata;
    logic        e_mrrdy;
    logic [31:0] e_cnt;
  } vec_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mreq_t;

  vec_t  tv[$];
  mreq_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // memory-side monitor: every accepted request must match the queue head
  always @(negedge clk) begin
    if (!rst && (mem_ren || mem_wen) && mem_req_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: got addr %h want none", mem_addr);
      end else begin
        mreq_t e;
        e = sb.pop_front();
        chk("sb_type", {31'd0, mem_wen}, {31'd0, e.wr});
        chk("sb_addr", mem_addr, e.addr);
        if (e.wr) begin
          chk("sb_wdata", mem_wdata, e.wdata);
          chk("sb_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
        end
      end
    end
  end

  function automatic vec_t nv(input logic [31:0] cnt);
    vec_t v;
    v = '0;
    v.e_cnt = cnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst             = v.rst;
    PC              = v.pc;
    Inst_Req_Valid  = v.irv;
    Inst_Ready      = v.iready;
    Address         = v.addr;
    Write_data      = v.wdata;
    Write_strb      = v.wstrb;
    MemWrite        = v.mw;
    MemRead         = v.mr;
    Read_data_Ready = v.rdready;
    mem_req_ready   = v.mrr;
    mem_rdata       = v.mrdata;
    mem_rdata_valid = v.mrvalid;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d_", i);
    chk({p, "irdy"}, {31'd0, Inst_Req_Ready}, {31'd0, v.e_irdy});
    chk({p, "mrdy"}, {31'd0, Mem_Req_Ready}, {31'd0, v.e_mrdy});
    chk({p, "ren"}, {31'd0, mem_ren}, {31'd0, v.e_ren});
    chk({p, "wen"}, {31'd0, mem_wen}, {31'd0, v.e_wen});
    chk({p, "ival"}, {31'd0, Inst_Valid}, {31'd0, v.e_ival});
    chk({p, "rval"}, {31'd0, Read_data_Valid}, {31'd0, v.e_rval});
    chk({p, "mrrdy"}, {31'd0, mem_rdata_ready}, {31'd0, v.e_mrrdy});
    chk({p, "cnt"}, conflict_cnt, v.e_cnt);
    if (v.e_ren || v.e_wen)
      chk({p, "addr"}, mem_addr, v.e_addr);
    if (v.e_wen) begin
      chk({p, "wdata"}, mem_wdata, v.e_wdata);
      chk({p, "wstrb"}, {28'd0, mem_wstrb}, {28'd0, v.e_wstrb});
    end
    if (v.e_ival)
      chk({p, "instr"}, Instruction, v.e_instr);
    if (v.e_rval)
      chk({p, "rdata"}, Read_data, v.e_rdata);
  endtask

  initial begin
    vec_t v;
    mreq_t m;

    // reset held with requests present: nothing may be accepted
    v = nv(0); v.rst = 1; v.mr = 1; v.irv = 1; v.pc = 'h10;
    tv.push_back(v);
    // fetch 0x100
    v = nv(0); v.irv = 1; v.pc = 'h100; v.e_irdy = 1;
    tv.push_back(v);
    v = nv(0); v.mrr = 1; v.e_ren = 1; v.e_addr = 'h100;
    tv.push_back(v);
    v = nv(0); v.mrdata = 'h24020005; v.mrvalid = 1; v.iready = 1;
    v.e_ival = 1; v.e_instr = 'h24020005; v.e_mrrdy = 1;
    tv.push_back(v);
    v = nv(0);
    tv.push_back(v);
    // read 0x200 vs fetch 0x104: read first, one conflict
    v = nv(0); v.mr = 1; v.addr = 'h200; v.irv = 1; v.pc = 'h104;
    v.e_mrdy = 1;
    tv.push_back(v);
    v = nv(1); v.irv = 1; v.pc = 'h104; v.mrr = 1;
    v.e_ren = 1; v.e_addr = 'h200;
    tv.push_back(v);
    v = nv(1); v.irv = 1; v.pc = 'h104; v.mrdata = 'h11112222;
    v.mrvalid = 1; v.rdready = 1;
    v.e_rval = 1; v.e_rdata = 'h11112222; v.e_mrrdy = 1;
    tv.push_back(v);
    v = nv(1); v.irv = 1; v.pc = 'h104; v.e_irdy = 1;
    tv.push_back(v);
    v = nv(1); v.mrr = 1; v.e_ren = 1; v.e_addr = 'h104;
    tv.push_back(v);
    v = nv(1); v.mrdata = 'h8C430000; v.mrvalid = 1; v.iready = 1;
    v.e_ival = 1; v.e_instr = 'h8C430000; v.e_mrrdy = 1;
    tv.push_back(v);
    // write+read together with a fetch: write wins, conflict 2
    v = nv(1); v.mw = 1; v.mr = 1; v.irv = 1; v.pc = 'h108;
    v.addr = 'h300; v.wdata = 'hDEADBEEF; v.wstrb = 4'b0011;
    v.e_mrdy = 1;
    tv.push_back(v);
    // write held off three cycles, payload must stay put
    for (int k = 0; k < 4; k++) begin
      v = nv(2); v.mr = 1; v.addr = 'h300; v.mrr = (k == 3);
      v.e_wen = 1; v.e_addr = 'h300;
      v.e_wdata = 'hDEADBEEF; v.e_wstrb = 4'b0011;
      tv.push_back(v);
    end
    // deferred read taken on next idle, fetch conflicts again
    v = nv(2); v.mr = 1; v.addr = 'h300; v.irv = 1; v.pc = 'h108;
    v.e_mrdy = 1;
    tv.push_back(v);
    v = nv(3); v.mrr = 1; v.e_ren = 1; v.e_addr = 'h300;
    tv.push_back(v);
    // response backpressure for two cycles
    for (int k = 0; k < 3; k++) begin
      v = nv(3); v.mrdata = 'hCAFEF00D; v.mrvalid = 1;
      v.rdready = (k == 2);
      v.e_rval = 1; v.e_rdata = 'hCAFEF00D; v.e_mrrdy = (k == 2);
      tv.push_back(v);
    end
    // unsolicited response in idle is dropped
    v = nv(3); v.mrvalid = 1; v.mrdata = 'h55; v.rdready = 1;
    v.iready = 1;
    tv.push_back(v);

    rst = 1'b1;
    drive(nv(0) | {1'b1, {($bits(vec_t)-1){1'b0}}});
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tv[i]);
      if (tv[i].e_irdy) begin
        m = '0; m.addr = tv[i].pc;
        sb.push_back(m);
      end
      if (tv[i].e_mrdy) begin
        m.wr = tv[i].mw; m.addr = tv[i].addr;
        m.wdata = tv[i].wdata; m.wstrb = tv[i].wstrb;
        sb.push_back(m);
      end
      #2;
      check_vec(i, tv[i]);
    end

    // reset pulsed in the middle of a read response
    @(posedge clk); #1;
    drive(nv(0));
    MemRead = 1; Address = 'h400;
    m = '0; m.addr = 'h400; sb.push_back(m);
    @(posedge clk); #1;
    MemRead = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0; Read_data_Ready = 1;
    #1;
    chk("rsp_before_rst", {31'd0, mem_rdata_ready}, 32'd1);
    mem_rdata_valid = 1; mem_rdata = 'h77;
    rst = 1;
    #1;
    chk("rst_rval", {31'd0, Read_data_Valid}, 32'd0);
    chk("rst_mrrdy", {31'd0, mem_rdata_ready}, 32'd0);
    chk("rst_cnt", conflict_cnt, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    #2;
    chk("late_rval", {31'd0, Read_data_Valid}, 32'd0);
    chk("late_mrrdy", {31'd0, mem_rdata_ready}, 32'd0);
    @(posedge clk); #1;
    mem_rdata_valid = 0; Read_data_Ready = 0;
    Inst_Req_Valid = 1; PC = 'h500;
    m = '0; m.addr = 'h500; sb.push_back(m);
    #2;
    chk("post_irdy", {31'd0, Inst_Req_Ready}, 32'd1);
    @(posedge clk); #1;
    Inst_Req_Valid = 0; mem_req_ready = 1;
    #2;
    chk("post_ren", {31'd0, mem_ren}, 32'd1);
    chk("post_addr", mem_addr, 32'h500);
    @(posedge clk); #1;
    mem_req_ready = 0; mem_rdata = 'h12345678;
    mem_rdata_valid = 1; Inst_Ready = 1;
    #2;
    chk("post_ival", {31'd0, Inst_Valid}, 32'd1);
    chk("post_instr", Instruction, 32'h12345678);
    @(posedge clk); #1;
    mem_rdata_valid = 0; Inst_Ready = 0;
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
